seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SCAN_DIV, 100000, clk cycles each digit is driven; legal range >= 2.
REQ-002 HOLD_FRAMES, 250, minimum frames an owner keeps the display while the other requester waits; legal range >= 1.
REQ-003 BLINK_FRAMES, 125, frames per blink half-period; used only with SEG_BLINK_EN.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst_n  in  1  synchronous reset, active-low.
REQ-006 p1_req  in  1  player-1 source requests the display.
REQ-007 p1_digits  in  16  four hex nibbles; [3:0] is the rightmost digit.
REQ-008 p2_req  in  1  player-2 source requests the display.
REQ-009 p2_digits  in  16  same layout as p1_digits.
REQ-010 blink_mask  in  4  per-digit blink enable; bit i maps to digit i.
REQ-011 p1_grant  out  1  player 1 owns the display.
REQ-012 p2_grant  out  1  player 2 owns the display.
REQ-013 an  out  4  anode enables, active-low; an[0] is the rightmost digit.
REQ-014 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-015 All outputs SHALL be registered; p1_grant and p2_grant SHALL never be high together.
REQ-016 FSM states SHALL be IDLE and SCAN; in IDLE an=4'b1111, seg=7'b1111111, both grants low.
REQ-017 IDLE->SCAN: the cycle after any req is sampled high, set the grant, snapshot that source's digits, digit index=0, an=4'b1110.
REQ-018 Tie on entry from IDLE: both reqs high SHALL grant the source not granted last; after reset, p1 wins.
REQ-019 Each digit SHALL be held SCAN_DIV cycles, then digit index +1; the sequence is 0,1,2,3 and wraps to 0; a frame is 4*SCAN_DIV cycles.
REQ-020 Digit data SHALL come only from the frame-start snapshot; input changes mid-frame are invisible until the next frame.
REQ-021 seg SHALL be the hex decode of the selected nibble (0-F, standard 7-segment glyphs).
REQ-022 Ownership SHALL be re-evaluated only at a frame end. Rules: owner req high and other low -> keep; owner req low and other high -> switch; both low -> IDLE.
REQ-023 At a frame end with both reqs high, the controller SHALL switch once the owner has held HOLD_FRAMES frames; otherwise it keeps the owner. The hold counter clears on every grant change.
REQ-024 A req dropped mid-frame SHALL NOT truncate the frame; the grant stays high until the frame end.
REQ-025 Tick counter width SHALL be $clog2(SCAN_DIV); the hold and blink counters SHALL saturate or wrap without overflow into other state.

Reset
REQ-026 While rst_n=0 at a clk edge, the next state SHALL be IDLE with all counters 0, the last-granted marker set to p2, and outputs at their IDLE values; this applies equally mid-frame.

Configuration
REQ-027 Macro SEG_BLINK_EN.
  - Defined: a blink phase toggles every BLINK_FRAMES frames. While the phase is 1, digits with blink_mask[i]=1 SHALL show seg=7'b1111111; an is unchanged. The phase resets to 0 on reset.
  - Undefined: blink_mask is ignored and no blink counter is built.

Structure
REQ-028 Package seg_pkg SHALL hold NUM_DIGITS=4, the active-low SEG_BLANK and AN_OFF constants, and the state enum.
REQ-029 Hex decode SHALL live in one combinational sub-module, hex_to_7seg (4-bit in, 7-bit active-low out).

Verification (SCAN_DIV=4, HOLD_FRAMES=2, BLINK_FRAMES=2)
REQ-030 Reset, then p1_req=1 with p1_digits=16'h1234 -> next cycle p1_grant=1, an=1110, seg=4's code; an walks 1101, 1011, 0111 every 4 cycles.
REQ-031 Both reqs high from IDLE after reset -> p1 granted. After 2 full frames -> p2_grant=1 exactly at the frame boundary, never overlapping.
REQ-032 p1_digits changes 16'h1234->16'hABCD at cycle 6 of a frame -> digits 2 and 3 still show 2 and 1; the next frame shows D, C, B, A.
REQ-033 p1_req drops at cycle 3 of a frame with p2_req=0 -> p1_grant stays high to the frame end, then an=1111 and seg=7F.
REQ-034 rst_n=0 during digit 2 -> next cycle an=1111, both grants 0; after release, p1 wins the tie.
REQ-035 With SEG_BLINK_EN and blink_mask=4'b0001 -> digit 0 is blanked in frames 2-3 and 6-7; other digits are unaffected.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment and anode drives are active-low, so "all ones" means dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  typedef enum logic {
    OWN_P1,
    OWN_P2
  } owner_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Standard glyph table; lowercase forms are used for b and d.
  always_comb begin
    case (hex_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display controller shared by two requesters.
// Ownership changes only at frame ends; each frame shows a snapshot taken
// at its start. Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int HOLD_FRAMES  = 250,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p1_req,
  input  logic [15:0] p1_digits,
  input  logic        p2_req,
  input  logic [15:0] p2_digits,
  input  logic [3:0]  blink_mask,
  output logic        p1_grant,
  output logic        p2_grant,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  state_t        state_q, state_d;
  owner_t        own_q, own_d, last_q, last_d;
  logic [15:0]   snap_q, snap_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          frame_end, own_req, oth_req;
  logic [3:0]    nib_d, an_d, an_q;
  logic [6:0]    dec_seg, seg_d, seg_q;
  logic          p1g_d, p2g_d, p1g_q, p2g_q;

  assign own_req  = (own_q == OWN_P1) ? p1_req : p2_req;
  assign oth_req  = (own_q == OWN_P1) ? p2_req : p1_req;
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);

  // Next-state: entry arbitration from IDLE, digit/tick walk, frame-end ownership.
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    last_d    = last_q;
    snap_d    = snap_q;
    dig_d     = dig_q;
    tick_d    = tick_q;
    hold_d    = hold_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (p1_req || p2_req) begin
          state_d = SCAN;
          if (p1_req && (!p2_req || last_q == OWN_P2)) own_d = OWN_P1;
          else                                         own_d = OWN_P2;
          last_d = own_d;
          snap_d = (own_d == OWN_P1) ? p1_digits : p2_digits;
          dig_d  = '0;
          tick_d = '0;
          hold_d = '0;
        end
      end
      default: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (dig_q == DIG_LAST) begin
            frame_end = 1'b1;
            dig_d     = '0;
            if (!own_req && !oth_req) begin
              state_d = IDLE;
              hold_d  = '0;
            end else if (oth_req && (!own_req || hold_inc >= HOLD_MAX)) begin
              own_d  = (own_q == OWN_P1) ? OWN_P2 : OWN_P1;
              last_d = own_d;
              snap_d = (own_d == OWN_P1) ? p1_digits : p2_digits;
              hold_d = '0;
            end else begin
              snap_d = (own_q == OWN_P1) ? p1_digits : p2_digits;
              hold_d = hold_inc;
            end
          end else begin
            dig_d = dig_q + DW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
    endcase
  end

  assign nib_d = snap_d[{dig_d, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .hex_i (nib_d),
    .seg_o (dec_seg)
  );

  logic blank_dig;

`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // Count completed frames and flip the blink phase every BLINK_FRAMES of them.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign blank_dig = blink_ph_d & blink_mask[dig_d];
`else
  logic [4:0] unused_blink;
  assign unused_blink = {blink_mask, BLINK_FRAMES[0]};
  assign blank_dig    = 1'b0;
`endif

  // Output values for the coming cycle, so the registered outputs align with state.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    p1g_d = 1'b0;
    p2g_d = 1'b0;
    if (state_d == SCAN) begin
      an_d  = ~(4'b0001 << dig_d);
      seg_d = blank_dig ? SEG_BLANK : dec_seg;
      p1g_d = (own_d == OWN_P1);
      p2g_d = (own_d == OWN_P2);
    end
  end

  // FSM state, counters and registered outputs; reset forces IDLE even mid-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= OWN_P1;
      last_q  <= OWN_P2;
      dig_q   <= '0;
      tick_q  <= '0;
      hold_q  <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      p1g_q   <= 1'b0;
      p2g_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      snap_q  <= snap_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      p1g_q   <= p1g_d;
      p2g_q   <= p2g_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign p1_grant = p1g_q;
  assign p2_grant = p2g_q;

endmodule
